riscv_core_rob: RTL and testbench

RISCV_CORE_ROB -- requirements
Module: riscv_core_rob

---
 rtl/riscv_core_pkg.sv | 16 +
 rtl/riscv_core_rob_if.sv | 30 +++
 rtl/riscv_core_rob_ptr.sv | 25 ++
 rtl/riscv_core_rob.sv | 93 +++++++++
 tb/tb_riscv_core_rob.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_core_pkg.sv
// Shared reorder-buffer constants and entry layout.
package riscv_core_pkg;

    localparam int unsigned ROB_DEPTH  = 16;
    localparam int unsigned ROB_SLOT_W = 4;
    localparam int unsigned ROB_CNT_W  = 5;
    localparam int unsigned PREG_W     = 5;

    typedef struct packed {
        logic              valid;
        logic              pending;
        logic              wen;
        logic [PREG_W-1:0] preg;
    } rob_entry_t;

endpackage

// File: rtl/riscv_core_rob_if.sv
// Decode / writeback / commit bus of the reorder buffer.
interface riscv_core_rob_if;
    import riscv_core_pkg::*;

    logic                  rob_alloc_req_val;
    logic                  rob_alloc_req_rdy;
    logic                  rob_alloc_req_wen;
    logic [PREG_W-1:0]     rob_alloc_req_preg;
    logic [ROB_SLOT_W-1:0] rob_alloc_resp_slot;
    logic                  rob_fill_val;
    logic [ROB_SLOT_W-1:0] rob_fill_slot;
    logic                  rob_commit_wen;
    logic [ROB_SLOT_W-1:0] rob_commit_slot;
    logic [PREG_W-1:0]     rob_commit_rf_waddr;

    modport master (
        output rob_alloc_req_val, rob_alloc_req_wen, rob_alloc_req_preg,
        output rob_fill_val, rob_fill_slot,
        input  rob_alloc_req_rdy, rob_alloc_resp_slot,
        input  rob_commit_wen, rob_commit_slot, rob_commit_rf_waddr
    );

    modport slave (
        input  rob_alloc_req_val, rob_alloc_req_wen, rob_alloc_req_preg,
        input  rob_fill_val, rob_fill_slot,
        output rob_alloc_req_rdy, rob_alloc_resp_slot,
        output rob_commit_wen, rob_commit_slot, rob_commit_rf_waddr
    );

endinterface

// File: rtl/riscv_core_rob_ptr.sv
// Wrapping slot pointer with increment enable and synchronous clear.
module riscv_core_rob_ptr
    import riscv_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clr,
    input  logic                  i_inc,
    output logic [ROB_SLOT_W-1:0] o_ptr
);

    logic [ROB_SLOT_W-1:0] r_ptr;

    // Pointer wraps 15 -> 0 through natural overflow of the slot width.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + ROB_SLOT_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/riscv_core_rob.sv
// 16-entry in-order reorder buffer.
// Optional feature: define RISCV_CORE_ROB_FLUSH_EN to add the rob_flush input.
module riscv_core_rob
    import riscv_core_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
`ifdef RISCV_CORE_ROB_FLUSH_EN
    input  logic               rob_flush,
`endif
    riscv_core_rob_if.slave    rob
);

    rob_entry_t            r_entries [ROB_DEPTH];
    logic [ROB_CNT_W-1:0]  r_count;
    logic [ROB_SLOT_W-1:0] w_head;
    logic [ROB_SLOT_W-1:0] w_tail;
    logic                  w_flush;
    logic                  w_rdy;
    logic                  w_alloc_fire;
    logic                  w_retire;
    rob_entry_t            w_head_entry;

`ifdef RISCV_CORE_ROB_FLUSH_EN
    assign w_flush = rob_flush;
`else
    assign w_flush = 1'b0;
`endif

    // Occupancy-only ready keeps decode off the commit timing path.
    assign w_rdy        = (r_count != ROB_CNT_W'(ROB_DEPTH));
    assign w_alloc_fire = rob.rob_alloc_req_val && w_rdy;
    assign w_head_entry = r_entries[w_head];
    assign w_retire     = w_head_entry.valid && !w_head_entry.pending && !w_flush;

    assign rob.rob_alloc_req_rdy   = w_rdy;
    assign rob.rob_alloc_resp_slot = w_tail;
    assign rob.rob_commit_wen      = w_retire && w_head_entry.wen;
    assign rob.rob_commit_slot     = w_head;
    assign rob.rob_commit_rf_waddr = w_head_entry.preg;

    riscv_core_rob_ptr u_head_ptr (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_flush),
        .i_inc (w_retire),
        .o_ptr (w_head)
    );

    riscv_core_rob_ptr u_tail_ptr (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_flush),
        .i_inc (w_alloc_fire),
        .o_ptr (w_tail)
    );

    // Entry array: fill clears pending, retire frees head, alloc claims tail.
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (rob.rob_fill_val && r_entries[rob.rob_fill_slot].valid) begin
                r_entries[rob.rob_fill_slot].pending <= 1'b0;
            end
            if (w_retire) begin
                r_entries[w_head].valid <= 1'b0;
            end
            if (w_alloc_fire) begin
                r_entries[w_tail] <= '{valid:   1'b1,
                                       pending: 1'b1,
                                       wen:     rob.rob_alloc_req_wen,
                                       preg:    rob.rob_alloc_req_preg};
            end
        end
    end

    // Occupancy counter; simultaneous alloc and retire cancel out.
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_count <= '0;
        end else begin
            case ({w_alloc_fire, w_retire})
                2'b10:   r_count <= r_count + ROB_CNT_W'(1);
                2'b01:   r_count <= r_count - ROB_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_core_rob.sv
// Self-checking bench for riscv_core_rob: in-order queue reference model plus commit scoreboard.
module tb_riscv_core_rob;
    import riscv_core_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
`ifdef RISCV_CORE_ROB_FLUSH_EN
    logic rob_flush = 1'b0;
`endif

    riscv_core_rob_if rob_bus ();

    riscv_core_rob dut (
        .clk       (clk),
        .reset     (reset),
`ifdef RISCV_CORE_ROB_FLUSH_EN
        .rob_flush (rob_flush),
`endif
        .rob       (rob_bus)
    );

    always #5 clk = ~clk;

    // Reference model: program-ordered list of live instructions.
    typedef struct {
        int slot;
        bit wen;
        int preg;
        bit done;
    } m_ent_t;

    typedef struct {
        int slot;
        int preg;
    } exp_t;

    m_ent_t mq[$];
    exp_t   exp_q[$];
    int     m_head = 0;
    int     m_tail = 0;
    bit     f_now  = 1'b0;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step(bit v, bit w, int p, bit fv, int fs, bit rst, bit fl);
        bit ret;
        int sz;
        @(negedge clk);
        check("rdy", 32'(rob_bus.rob_alloc_req_rdy), 32'(mq.size() != 16));
        check("resp_slot", 32'(rob_bus.rob_alloc_resp_slot), 32'(m_tail));
        check("commit_slot", 32'(rob_bus.rob_commit_slot), 32'(m_head));
        ret = 1'b0;
        if (mq.size() > 0) ret = mq[0].done;
        if (ret) begin
            check("commit_wen", 32'(rob_bus.rob_commit_wen), 32'(mq[0].wen));
            check("rf_waddr", 32'(rob_bus.rob_commit_rf_waddr), 32'(mq[0].preg));
        end else begin
            check("commit_wen_idle", 32'(rob_bus.rob_commit_wen), 32'(0));
        end

        reset                      = rst;
        f_now                      = fl;
        rob_bus.rob_alloc_req_val  = v;
        rob_bus.rob_alloc_req_wen  = w;
        rob_bus.rob_alloc_req_preg = 5'(p);
        rob_bus.rob_fill_val       = fv;
        rob_bus.rob_fill_slot      = 4'(fs);
`ifdef RISCV_CORE_ROB_FLUSH_EN
        rob_flush = fl;
        if (fl) begin
            #1;
            check("flush_commit_wen", 32'(rob_bus.rob_commit_wen), 32'(0));
        end
`endif

        if (rst || fl) begin
            mq.delete();
            exp_q.delete();
            m_head = 0;
            m_tail = 0;
        end else begin
            sz = mq.size();
            if (fv) begin
                foreach (mq[i]) if (mq[i].slot == fs) mq[i].done = 1'b1;
            end
            if (ret) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % 16;
            end
            if (v && sz < 16) begin
                mq.push_back('{slot: m_tail, wen: w, preg: p, done: 1'b0});
                if (w) exp_q.push_back('{slot: m_tail, preg: p});
                m_tail = (m_tail + 1) % 16;
            end
        end
    endtask

    // Commit monitor: every register-writing retire must match the next allocation in program order.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset && !f_now && rob_bus.rob_commit_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_commit: got slot %0d expected no commit at %0t",
                         rob_bus.rob_commit_slot, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_commit_slot", 32'(rob_bus.rob_commit_slot), 32'(e.slot));
                check("sb_commit_waddr", 32'(rob_bus.rob_commit_rf_waddr), 32'(e.preg));
            end
        end
    end

    initial begin
        int v, w, p, fv, fs, rst, fl;
        rob_bus.rob_alloc_req_val  = 1'b0;
        rob_bus.rob_alloc_req_wen  = 1'b0;
        rob_bus.rob_alloc_req_preg = '0;
        rob_bus.rob_fill_val       = 1'b0;
        rob_bus.rob_fill_slot      = '0;
        repeat (2) @(posedge clk);

        // Single alloc, fill next cycle, commit one cycle after fill.
        step(1, 1, 5, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Fill to full, then hold alloc: rejected, tail stays.
        for (int i = 0; i < 16; i++) step(1, 1, i + 8, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 31, 0, 0, 0, 0);

        // Full with head filled: retire and rejected alloc in the same cycle.
        step(1, 1, 31, 1, m_head, 0, 0);
        step(1, 1, 30, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Out-of-order fills 2,1,0 retire in order 0,1,2.
        step(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 20 + i, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Non-writing entry retires silently and head advances; stray fill ignored.
        step(1, 0, 17, 1, 9, 0, 0);
        step(0, 0, 0, 1, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset wins over a concurrent alloc and fill.
        step(1, 1, 4, 0, 0, 0, 0);
        step(1, 1, 6, 1, 4, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);

`ifdef RISCV_CORE_ROB_FLUSH_EN
        for (int i = 0; i < 3; i++) step(1, 1, 10 + i, 0, 0, 0, 0);
        step(0, 0, 0, 1, m_head, 0, 0);
        step(1, 1, 3, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
`endif

        // Randomized traffic with varying fill pressure.
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            w  = $urandom_range(0, 1);
            p  = $urandom_range(0, 31);
            fv = ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 4 : 8)) ? 1 : 0;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                fs = mq[$urandom_range(0, mq.size() - 1)].slot;
            else
                fs = $urandom_range(0, 15);
            rst = ($urandom_range(0, 399) == 0) ? 1 : 0;
            fl  = 0;
`ifdef RISCV_CORE_ROB_FLUSH_EN
            fl  = ($urandom_range(0, 149) == 0) ? 1 : 0;
`endif
            step(v[0], w[0], p, fv[0], fs, rst[0], fl[0]);
        end

        // Drain: fill the oldest unfinished entry each cycle, bounded.
        for (int c = 0; c < 64; c++) begin
            fv = 0;
            fs = 0;
            foreach (mq[i]) begin
                if (fv == 0 && !mq[i].done) begin
                    fv = 1;
                    fs = mq[i].slot;
                end
            end
            step(0, 0, 0, fv[0], fs, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        check("drain_model_empty", 32'(mq.size()), 32'(0));
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
